// File: rtl/switch_debounce.sv
// Four-channel push-switch debouncer: per channel a 2-flop synchronizer, a
// stability counter, and registered level / press / release / toggle outputs.

module switch_debounce_channel #(
   parameter int DEBOUNCE_LIMIT = 250000
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic level,
   output logic press,
   output logic rel,
   output logic toggle
);

   localparam int CW = $clog2(DEBOUNCE_LIMIT);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_LIMIT - 1);

   logic          sync1;
   logic          sync2;
   logic          state;
   logic [CW-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= pin;
         sync2 <= sync1;
      end
   end

   // Any single cycle of agreement restarts the count, so short bounces never qualify.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= 1'b0;
         count  <= '0;
         press  <= 1'b0;
         rel    <= 1'b0;
         toggle <= 1'b0;
      end else begin
         press <= 1'b0;
         rel   <= 1'b0;
         if (sync2 == state) begin
            count <= '0;
         end else if (count != LAST) begin
            count <= count + 1'b1;
         end else begin
            state <= sync2;
            count <= '0;
            press <= sync2;
            rel   <= ~sync2;
            if (sync2) begin
               toggle <= ~toggle;
            end
         end
      end
   end

   assign level = state;

endmodule

module switch_debounce #(
   parameter int DEBOUNCE_LIMIT = 250000
) (
   input  logic i_Clk,
   input  logic i_Rst,
   input  logic i_Switch_1,
   input  logic i_Switch_2,
   input  logic i_Switch_3,
   input  logic i_Switch_4,
   output logic o_Switch_1,
   output logic o_Switch_2,
   output logic o_Switch_3,
   output logic o_Switch_4,
   output logic o_Press_1,
   output logic o_Press_2,
   output logic o_Press_3,
   output logic o_Press_4,
   output logic o_Release_1,
   output logic o_Release_2,
   output logic o_Release_3,
   output logic o_Release_4,
   output logic o_Toggle_1,
   output logic o_Toggle_2,
   output logic o_Toggle_3,
   output logic o_Toggle_4
);

   logic [3:0] pins;
   logic [3:0] level;
   logic [3:0] press;
   logic [3:0] rel;
   logic [3:0] toggle;

   assign pins = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

   // Channels share nothing but clock and reset.
   for (genvar g = 0; g < 4; g++) begin : g_ch
      switch_debounce_channel #(
         .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
      ) u_ch (
         .clk    (i_Clk),
         .rst    (i_Rst),
         .pin    (pins[g]),
         .level  (level[g]),
         .press  (press[g]),
         .rel    (rel[g]),
         .toggle (toggle[g])
      );
   end

   assign o_Switch_1  = level[0];
   assign o_Switch_2  = level[1];
   assign o_Switch_3  = level[2];
   assign o_Switch_4  = level[3];
   assign o_Press_1   = press[0];
   assign o_Press_2   = press[1];
   assign o_Press_3   = press[2];
   assign o_Press_4   = press[3];
   assign o_Release_1 = rel[0];
   assign o_Release_2 = rel[1];
   assign o_Release_3 = rel[2];
   assign o_Release_4 = rel[3];
   assign o_Toggle_1  = toggle[0];
   assign o_Toggle_2  = toggle[1];
   assign o_Toggle_3  = toggle[2];
   assign o_Toggle_4  = toggle[3];

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with DEBOUNCE_LIMIT = 4; expected output
// vectors are queued as stimulus is applied and compared every clock.

module tb_switch_debounce;

  localparam int LIMIT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] pins = '0;

  logic [3:0] sw, prs, rel, tog;
  logic [15:0] out_vec;

  always #5 clk = ~clk;

  switch_debounce #(.DEBOUNCE_LIMIT(LIMIT)) dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .i_Switch_1  (pins[0]),
    .i_Switch_2  (pins[1]),
    .i_Switch_3  (pins[2]),
    .i_Switch_4  (pins[3]),
    .o_Switch_1  (sw[0]),
    .o_Switch_2  (sw[1]),
    .o_Switch_3  (sw[2]),
    .o_Switch_4  (sw[3]),
    .o_Press_1   (prs[0]),
    .o_Press_2   (prs[1]),
    .o_Press_3   (prs[2]),
    .o_Press_4   (prs[3]),
    .o_Release_1 (rel[0]),
    .o_Release_2 (rel[1]),
    .o_Release_3 (rel[2]),
    .o_Release_4 (rel[3]),
    .o_Toggle_1  (tog[0]),
    .o_Toggle_2  (tog[1]),
    .o_Toggle_3  (tog[2]),
    .o_Toggle_4  (tog[3])
  );

  assign out_vec = {tog, rel, prs, sw};

  // Scoreboard state
  logic [15:0] exp_q[$];
  logic [3:0]  exp_sw;
  logic [3:0]  exp_tog;
  int          checks = 0;
  int          errors = 0;

  // Pulse counters for channel 3
  int press3_cnt = 0;
  int rel3_cnt   = 0;
  always @(negedge clk) begin
    if (prs[2] === 1'b1) press3_cnt++;
    if (rel[2] === 1'b1) rel3_cnt++;
  end

  task automatic push(input int n, input logic [3:0] e_sw, input logic [3:0] e_prs,
                      input logic [3:0] e_rel, input logic [3:0] e_tog);
    repeat (n) exp_q.push_back({e_tog, e_rel, e_prs, e_sw});
  endtask

  task automatic check_vec(input string tag, input logic [15:0] exp);
    checks++;
    assert (out_vec === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, out_vec, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run(input int n, input string tag);
    logic [15:0] e;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s observed=no_entry expected=queued_vector", tag);
      end else begin
        e = exp_q.pop_front();
        check_vec(tag, e);
      end
    end
  endtask

  // Drive a new stable pin pattern and expect the qualified change LIMIT+2 edges later.
  task automatic clean_change(input logic [3:0] nw, input string tag);
    logic [3:0] chg, e_prs, e_rel;
    chg   = nw ^ exp_sw;
    e_prs = chg & nw;
    e_rel = chg & ~nw;
    pins  = nw;
    push(LIMIT + 1, exp_sw, 4'b0000, 4'b0000, exp_tog);
    exp_sw  = nw;
    exp_tog = exp_tog ^ e_prs;
    push(1, exp_sw, e_prs, e_rel, exp_tog);
    push(1, exp_sw, 4'b0000, 4'b0000, exp_tog);
    run(LIMIT + 3, tag);
  endtask

  initial begin
    logic [7:0] pat;
    logic [2:0] tog_seq;
    int p0, r0;

    exp_sw  = '0;
    exp_tog = '0;

    // Reset state
    push(3, 4'b0, 4'b0, 4'b0, 4'b0);
    run(3, "reset_hold");
    rst = 1'b0;
    push(2, 4'b0, 4'b0, 4'b0, 4'b0);
    run(2, "idle");

    // Clean press / release on ch1
    clean_change(4'b0001, "ch1_press");
    clean_change(4'b0000, "ch1_release");

    // Bounce rejection on ch2: 1,1,1,0,1,1,1,0 then hold 1
    pat = 8'b0111_0111;
    push(13, exp_sw, 4'b0000, 4'b0000, exp_tog);
    exp_sw  = exp_sw | 4'b0010;
    exp_tog = exp_tog ^ 4'b0010;
    push(1, exp_sw, 4'b0010, 4'b0000, exp_tog);
    push(1, exp_sw, 4'b0000, 4'b0000, exp_tog);
    for (int i = 0; i < 8; i++) begin
      pins[1] = pat[i];
      run(1, "ch2_bounce");
    end
    pins[1] = 1'b1;
    run(7, "ch2_settle");
    clean_change(4'b0000, "ch2_release");

    // Toggle sequence on ch3
    tog_seq = 3'b101;
    p0 = press3_cnt;
    r0 = rel3_cnt;
    for (int k = 0; k < 3; k++) begin
      clean_change(4'b0100, "ch3_press");
      checks++;
      assert (tog[2] === tog_seq[k]) else begin
        errors++;
        $error("FAIL ch3_toggle observed=%b expected=%b", tog[2], tog_seq[k]);
      end
      clean_change(4'b0000, "ch3_release");
    end
    check_int("ch3_press_count", press3_cnt - p0, 3);
    check_int("ch3_release_count", rel3_cnt - r0, 3);

    // Simultaneous channels, then ch4 alone
    clean_change(4'b1111, "all_press");
    clean_change(4'b0111, "ch4_release");
    clean_change(4'b1111, "ch4_repress");

    // Asynchronous reset with all switches held
    #2 rst = 1'b1;
    #1 check_vec("rst_async", 16'h0000);
    exp_sw  = '0;
    exp_tog = '0;
    push(1, 4'b0, 4'b0, 4'b0, 4'b0);
    run(1, "rst_held");
    rst = 1'b0;
    clean_change(4'b1111, "rst_release_press");
    clean_change(4'b0000, "all_release");

    // Reset while ch1 is mid-count
    pins[0] = 1'b1;
    push(4, exp_sw, 4'b0000, 4'b0000, exp_tog);
    run(4, "ch1_counting");
    #2 rst = 1'b1;
    #1 check_vec("rst_midcount", 16'h0000);
    exp_tog = '0;
    push(1, 4'b0, 4'b0, 4'b0, 4'b0);
    run(1, "rst_held2");
    rst = 1'b0;
    clean_change(4'b0001, "ch1_after_rst");

    check_int("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
